celownik_draw: RTL and testbench

- Reads the 64x64 12-bit crosshair image ROM and overlays it on the VGA pixel stream, centred on a mouse-supplied position.
- Sits between the timing/background stage and the VGA output stage.
- Drives the ROM address `{addry[5:0], addrx[5:0]}` and consumes its 1-cycle registered `rgb`.
- Delays all timing signals to match the ROM latency.
- Latches the position once per frame to prevent tearing.

---
 rtl/celownik_draw_if.sv | 39 +++
 rtl/celownik_draw.sv | 123 ++++++++++++
 tb/tb_celownik_draw.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/celownik_draw_if.sv
// Pixel-stream bus for the crosshair overlay stage.
// Carries the incoming VGA timing/colour, the mouse position, the ROM
// address/data pair and the delayed, composited VGA timing/colour.
//   slave  : the overlay block (consumes *_in, xpos, ypos, rom_rgb)
//   master : the surrounding system (drives *_in, xpos, ypos, rom_rgb)
interface celownik_draw_if;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  modport slave (
    input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
    input  rgb_in, xpos, ypos, rom_rgb,
    output rom_addr, hcount_out, hsync_out, hblnk_out, vcount_out,
    output vsync_out, vblnk_out, rgb_out
  );

  modport master (
    output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
    output rgb_in, xpos, ypos, rom_rgb,
    input  rom_addr, hcount_out, hsync_out, hblnk_out, vcount_out,
    input  vsync_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/celownik_draw.sv
// Crosshair overlay: addresses a 64x64 12-bit image ROM around the mouse
// position and composites it onto the VGA pixel stream.
// Ports:
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : celownik_draw_if.slave (timing/colour in, position,
//              rom_addr/rom_rgb, timing/colour out delayed by 2 cycles)
// The image ROM has a registered read, so its output register acts as the
// colour's second pipeline stage; the final select only muxes registered
// values so every *_out port carries exactly two cycles of latency.
module celownik_draw #(
  parameter int unsigned CENTER_X  = 32,
  parameter int unsigned CENTER_Y  = 32,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input logic            clk,
  input logic            rst,
  celownik_draw_if.slave bus
);

  localparam int unsigned REL_W = 14;

  logic        vblnk_d;
  logic [11:0] xpos_l;
  logic [11:0] ypos_l;

  logic [REL_W-1:0] rel_x;
  logic [REL_W-1:0] rel_y;
  logic             in_win;

  logic [10:0] hcount_d1, vcount_d1;
  logic        hsync_d1, hblnk_d1, vsync_d1, vblnk_d1;
  logic        in_win_d1, blank_d1;
  logic [11:0] rgb_d1;

  logic        in_win_d2, blank_d2;
  logic [11:0] rgb_d2;

  // Position latch: sampled only on a rising vblnk edge to avoid tearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_d <= 1'b0;
      xpos_l  <= 12'd0;
      ypos_l  <= 12'd0;
    end else begin
      vblnk_d <= bus.vblnk_in;
      if (bus.vblnk_in && !vblnk_d) begin
        xpos_l <= bus.xpos;
        ypos_l <= bus.ypos;
      end
    end
  end

  // Image-relative coordinates; modular 14-bit maths, so a value in 0..63
  // is exactly one whose upper bits are all zero (negatives never alias in).
  always_comb begin
    rel_x  = REL_W'(bus.hcount_in) - REL_W'(xpos_l) + REL_W'(CENTER_X);
    rel_y  = REL_W'(bus.vcount_in) - REL_W'(ypos_l) + REL_W'(CENTER_Y);
    in_win = (rel_x[REL_W-1:6] == 8'd0) && (rel_y[REL_W-1:6] == 8'd0);
  end

  // Stage 1: ROM address plus registered copies of everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rom_addr <= 12'd0;
      hcount_d1    <= 11'd0;
      vcount_d1    <= 11'd0;
      hsync_d1     <= 1'b0;
      hblnk_d1     <= 1'b0;
      vsync_d1     <= 1'b0;
      vblnk_d1     <= 1'b0;
      in_win_d1    <= 1'b0;
      blank_d1     <= 1'b0;
      rgb_d1       <= 12'd0;
    end else begin
      bus.rom_addr <= {rel_y[5:0], rel_x[5:0]};
      hcount_d1    <= bus.hcount_in;
      vcount_d1    <= bus.vcount_in;
      hsync_d1     <= bus.hsync_in;
      hblnk_d1     <= bus.hblnk_in;
      vsync_d1     <= bus.vsync_in;
      vblnk_d1     <= bus.vblnk_in;
      in_win_d1    <= in_win;
      blank_d1     <= bus.hblnk_in | bus.vblnk_in;
      rgb_d1       <= bus.rgb_in;
    end
  end

  // Stage 2: timing outputs and the composite selects, in step with rom_rgb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hcount_out <= 11'd0;
      bus.vcount_out <= 11'd0;
      bus.hsync_out  <= 1'b0;
      bus.hblnk_out  <= 1'b0;
      bus.vsync_out  <= 1'b0;
      bus.vblnk_out  <= 1'b0;
      in_win_d2      <= 1'b0;
      blank_d2       <= 1'b0;
      rgb_d2         <= 12'd0;
    end else begin
      bus.hcount_out <= hcount_d1;
      bus.vcount_out <= vcount_d1;
      bus.hsync_out  <= hsync_d1;
      bus.hblnk_out  <= hblnk_d1;
      bus.vsync_out  <= vsync_d1;
      bus.vblnk_out  <= vblnk_d1;
      in_win_d2      <= in_win_d1;
      blank_d2       <= blank_d1;
      rgb_d2         <= rgb_d1;
    end
  end

  // Composite: black in blanking, ROM pixel unless transparent, else background.
  always_comb begin
    bus.rgb_out = rgb_d2;
    if (blank_d2) begin
      bus.rgb_out = 12'd0;
    end else if (in_win_d2 && (bus.rom_rgb != KEY_COLOR)) begin
      bus.rgb_out = bus.rom_rgb;
    end
  end

endmodule

// File: tb/tb_celownik_draw.sv
// Directed bench for celownik_draw with a registered-read image ROM model.
module tb_celownik_draw;

  logic clk = 1'b0;
  logic rst = 1'b1;

  celownik_draw_if bus();

  celownik_draw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [4096];

  always @(posedge clk) bus.rom_rgb <= rom[bus.rom_addr];

  typedef struct {
    logic [11:0] px;
    logic [11:0] py;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hb;
    logic [11:0] rgb;
    logic [11:0] addr;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs [13];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [11:0] cur_x = 12'd0;
  logic [11:0] cur_y = 12'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Produce a vblnk rising edge with the given position on xpos/ypos.
  task automatic latch_pos(input logic [11:0] x, input logic [11:0] y);
    bus.xpos     = x;
    bus.ypos     = y;
    bus.vblnk_in = 1'b0;
    step();
    bus.vblnk_in = 1'b1;
    step();
    bus.vblnk_in = 1'b0;
    step();
    cur_x = x;
    cur_y = y;
  endtask

  // Drive one pixel, check rom_addr after 1 cycle and outputs after 2.
  task automatic run_pix(input string name, input logic [10:0] hc, input logic [10:0] vc,
                         input logic hb, input logic vb, input logic [11:0] rgb,
                         input logic [11:0] addr, input logic [11:0] exp_rgb);
    bus.hcount_in = hc;
    bus.vcount_in = vc;
    bus.hsync_in  = hc[0];
    bus.vsync_in  = vc[0];
    bus.hblnk_in  = hb;
    bus.vblnk_in  = vb;
    bus.rgb_in    = rgb;
    step();
    chk({name, ".addr"}, 32'(bus.rom_addr), 32'(addr));
    step();
    chk({name, ".rgb"},    32'(bus.rgb_out),    32'(exp_rgb));
    chk({name, ".hcount"}, 32'(bus.hcount_out), 32'(hc));
    chk({name, ".vcount"}, 32'(bus.vcount_out), 32'(vc));
    chk({name, ".hsync"},  32'(bus.hsync_out),  32'(hc[0]));
    chk({name, ".vsync"},  32'(bus.vsync_out),  32'(vc[0]));
    chk({name, ".hblnk"},  32'(bus.hblnk_out),  32'(hb));
    chk({name, ".vblnk"},  32'(bus.vblnk_out),  32'(vb));
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 12'h0F0;
    rom[12'h821] = 12'hF0F;
    rom[12'h596] = 12'h00F;
    bus.rom_rgb   = 12'd0;
    bus.hcount_in = 11'd0;
    bus.vcount_in = 11'd0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.hblnk_in  = 1'b0;
    bus.vblnk_in  = 1'b0;
    bus.rgb_in    = 12'd0;
    bus.xpos      = 12'd0;
    bus.ypos      = 12'd0;

    vecs = '{
      '{12'd400,  12'd300,  11'd400,  11'd300, 1'b0, 12'h123, 12'h820, 12'h0F0},
      '{12'd400,  12'd300,  11'd368,  11'd300, 1'b0, 12'h123, 12'h800, 12'h0F0},
      '{12'd400,  12'd300,  11'd431,  11'd300, 1'b0, 12'h123, 12'h83F, 12'h0F0},
      '{12'd400,  12'd300,  11'd367,  11'd300, 1'b0, 12'h123, 12'h83F, 12'h123},
      '{12'd400,  12'd300,  11'd432,  11'd300, 1'b0, 12'h123, 12'h800, 12'h123},
      '{12'd400,  12'd300,  11'd401,  11'd300, 1'b0, 12'hABC, 12'h821, 12'hABC},
      '{12'd400,  12'd300,  11'd400,  11'd300, 1'b1, 12'h123, 12'h820, 12'h000},
      '{12'd400,  12'd300,  11'd400,  11'd268, 1'b0, 12'h123, 12'h020, 12'h0F0},
      '{12'd400,  12'd300,  11'd400,  11'd267, 1'b0, 12'h123, 12'hFE0, 12'h123},
      '{12'd10,   12'd10,   11'd0,    11'd0,   1'b0, 12'h456, 12'h596, 12'h00F},
      '{12'd10,   12'd10,   11'd41,   11'd0,   1'b0, 12'h456, 12'h5BF, 12'h0F0},
      '{12'd10,   12'd10,   11'd1020, 11'd0,   1'b0, 12'h456, 12'h592, 12'h456},
      '{12'd4095, 12'd4095, 11'd400,  11'd300, 1'b0, 12'h789, 12'h371, 12'h789}
    };

    // Reset state
    step();
    step();
    chk("reset.rgb",    32'(bus.rgb_out),    32'd0);
    chk("reset.addr",   32'(bus.rom_addr),   32'd0);
    chk("reset.hcount", 32'(bus.hcount_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_x = 12'hFFF;

    // Table of single-pixel lookups
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].px != cur_x || vecs[i].py != cur_y) latch_pos(vecs[i].px, vecs[i].py);
      run_pix($sformatf("vec%0d", i), vecs[i].hc, vecs[i].vc, vecs[i].hb, 1'b0,
              vecs[i].rgb, vecs[i].addr, vecs[i].exp_rgb);
    end

    // Mid-frame position change only takes effect after the next vblnk edge
    latch_pos(12'd400, 12'd300);
    bus.xpos = 12'd600;
    run_pix("midframe_old",     11'd400, 11'd300, 1'b0, 1'b0, 12'h123, 12'h820, 12'h0F0);
    run_pix("midframe_new_off", 11'd600, 11'd300, 1'b0, 1'b0, 12'h123, 12'h828, 12'h123);
    run_pix("edge_same_cycle",  11'd400, 11'd300, 1'b0, 1'b1, 12'h123, 12'h820, 12'h000);
    run_pix("after_edge_new",   11'd600, 11'd300, 1'b0, 1'b0, 12'h123, 12'h820, 12'h0F0);
    run_pix("after_edge_old",   11'd400, 11'd300, 1'b0, 1'b0, 12'h123, 12'h818, 12'h123);

    // Asynchronous reset mid-line, then 2-cycle latency from release
    bus.hcount_in = 11'd700;
    bus.hsync_in  = 1'b1;
    bus.rgb_in    = 12'h123;
    step();
    step();
    chk("pre_reset.hcount", 32'(bus.hcount_out), 32'd700);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset.hcount", 32'(bus.hcount_out), 32'd0);
    chk("async_reset.hsync",  32'(bus.hsync_out),  32'd0);
    chk("async_reset.rgb",    32'(bus.rgb_out),    32'd0);
    chk("async_reset.addr",   32'(bus.rom_addr),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.hcount_in = 11'd5;
    bus.hsync_in  = 1'b1;
    step();
    chk("release_1cyc.hcount", 32'(bus.hcount_out), 32'd0);
    step();
    chk("release_2cyc.hcount", 32'(bus.hcount_out), 32'd5);
    chk("release_2cyc.hsync",  32'(bus.hsync_out),  32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
